// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide scheduler.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OpNone  = 3'd0,
    OpMult  = 3'd1,
    OpMultu = 3'd2,
    OpDiv   = 3'd3,
    OpDivu  = 3'd4,
    OpMthi  = 3'd5,
    OpMtlo  = 3'd6
  } muldiv_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StCommit
  } muldiv_state_e;

  localparam int unsigned TimeoutDefault = 64;

  function automatic logic is_long_op(input muldiv_op_e op);
    return op inside {OpMult, OpMultu, OpDiv, OpDivu};
  endfunction

endpackage

// File: rtl/muldiv_watchdog.sv
// Cycle counter for the WAIT state; flags the last permitted cycle.
module muldiv_watchdog #(
  parameter int unsigned LIMIT = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CntW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CntW-1:0] Last = CntW'(LIMIT - 1);

  logic [CntW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == Last);

endmodule

// File: rtl/muldiv_scheduler.sv
// Sequences the multi-cycle mul/div engine and owns the architectural HI/LO registers.
module muldiv_scheduler
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  input  logic [2:0]       i_req_op,
  input  logic [WIDTH-1:0] i_req_a,
  input  logic [WIDTH-1:0] i_req_b,
  input  logic             i_flush,
  output logic             o_stall,
  output logic             o_unit_start,
  output logic             o_unit_abort,
  output logic             o_unit_is_div,
  output logic             o_unit_signed,
  output logic [WIDTH-1:0] o_unit_a,
  output logic [WIDTH-1:0] o_unit_b,
  input  logic             i_unit_done,
  input  logic [WIDTH-1:0] i_unit_hi,
  input  logic [WIDTH-1:0] i_unit_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_done,
  output logic             o_timeout_err
);

  muldiv_state_e   r_state, w_state_next;
  muldiv_op_e      w_op;
  logic            w_req_ok, w_is_div, w_div_zero, w_accept;
  logic            w_wd_clear, w_wd_en, w_expired, w_capture, w_commit;
  logic            r_dz_done, r_is_div, r_signed;
  logic [WIDTH-1:0] r_unit_a, r_unit_b, r_hi, r_lo, r_pend_hi, r_pend_lo;

  assign w_op       = muldiv_op_e'(i_req_op);
  assign w_req_ok   = i_req_valid && !i_flush && (r_state == StIdle);
  assign w_is_div   = (w_op == OpDiv) || (w_op == OpDivu);
  assign w_div_zero = w_is_div && (i_req_b == '0);
  assign w_accept   = w_req_ok && is_long_op(w_op) && !w_div_zero;

  muldiv_watchdog #(
    .LIMIT(TIMEOUT)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_wd_clear),
    .i_enable (w_wd_en),
    .o_expired(w_expired)
  );

  always_comb begin
    w_state_next  = r_state;
    o_stall       = 1'b0;
    o_unit_start  = 1'b0;
    o_unit_abort  = 1'b0;
    o_timeout_err = 1'b0;
    w_wd_clear    = 1'b0;
    w_wd_en       = 1'b0;
    w_capture     = 1'b0;
    w_commit      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          o_stall      = 1'b1;
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        o_stall = 1'b1;
        if (i_flush) begin
          o_unit_abort = 1'b1;
          w_state_next = StIdle;
        end else begin
          o_unit_start = 1'b1;
          w_wd_clear   = 1'b1;
          w_state_next = StWait;
        end
      end
      StWait: begin
        o_stall = 1'b1;
        w_wd_en = 1'b1;
        // Flush beats a same-cycle done; done beats the final watchdog cycle.
        if (i_flush) begin
          o_unit_abort = 1'b1;
          w_state_next = StIdle;
        end else if (i_unit_done) begin
          w_capture    = 1'b1;
          w_state_next = StCommit;
        end else if (w_expired) begin
          o_unit_abort  = 1'b1;
          o_timeout_err = 1'b1;
          w_state_next  = StIdle;
        end
      end
      StCommit: begin
        w_commit     = !i_flush;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= StIdle;
      r_unit_a  <= '0;
      r_unit_b  <= '0;
      r_is_div  <= 1'b0;
      r_signed  <= 1'b0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_dz_done <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_dz_done <= w_req_ok && w_div_zero;
      if (w_accept) begin
        r_unit_a <= i_req_a;
        r_unit_b <= i_req_b;
        r_is_div <= w_is_div;
        r_signed <= (w_op == OpMult) || (w_op == OpDiv);
      end
      if (w_capture) begin
        r_pend_hi <= i_unit_hi;
        r_pend_lo <= i_unit_lo;
      end
      if (w_commit) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end else if (w_req_ok && (w_op == OpMthi)) begin
        r_hi <= i_req_a;
      end else if (w_req_ok && (w_op == OpMtlo)) begin
        r_lo <= i_req_a;
      end
    end
  end

  assign o_unit_a      = r_unit_a;
  assign o_unit_b      = r_unit_b;
  assign o_unit_is_div = r_is_div;
  assign o_unit_signed = r_signed;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_done        = w_commit || r_dz_done;

endmodule

// File: doc/muldiv_scheduler.md
Name: muldiv_scheduler

Overview:
- Sequences the multi-cycle multiply/divide engine used by the EX stage and owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from EX and issues long operations to the engine with a start/done handshake.
- Stalls the pipeline while an operation is in flight and commits results to HI/LO exactly once.
- Handles flush, divide-by-zero bypass and a watchdog timeout.

Parameters:
- WIDTH, 32, operand/HI/LO width
- TIMEOUT, 64, max cycles in WAIT before abort; minimum value 2

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  1  EX holds a muldiv/mthi/mtlo instruction
- req_op  in  3  op code from muldiv_pkg: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6
- req_a  in  WIDTH  rs operand
- req_b  in  WIDTH  rt operand
- flush  in  1  exception/flush kills the EX instruction
- stall  out  1  freeze IF..EX
- unit_start  out  1  one-cycle start pulse to engine
- unit_abort  out  1  one-cycle cancel pulse to engine
- unit_is_div  out  1  0 = multiply, 1 = divide
- unit_signed  out  1  signed operation
- unit_a  out  WIDTH  latched operand a
- unit_b  out  WIDTH  latched operand b
- unit_done  in  1  engine result valid (single-cycle pulse)
- unit_hi  in  WIDTH  product high / remainder
- unit_lo  in  WIDTH  product low / quotient
- hi  out  WIDTH  architectural HI
- lo  out  WIDTH  architectural LO
- done  out  1  one-cycle pulse on commit
- timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (rst=0, async): state IDLE. hi, lo, unit_a, unit_b, counter = 0. All pulses and stall = 0.
- States: IDLE, ISSUE, WAIT, COMMIT.
- IDLE:
  - MTHI/MTLO with req_valid & !flush: hi (or lo) <= req_a at the next edge. No stall, state stays IDLE.
  - DIV/DIVU with req_b==0: no issue, HI/LO unchanged, no stall, done pulses next cycle.
  - Otherwise MULT..DIVU with req_valid & !flush: latch operands, unit_is_div and unit_signed. Go to ISSUE. stall = 1 combinationally in this same cycle.
  - NONE or !req_valid: nothing happens.
- ISSUE: unit_start = 1 for exactly this cycle, counter <= 0, go to WAIT. stall = 1.
- WAIT: stall = 1, counter increments each cycle.
  - unit_done: latch unit_hi/unit_lo into pending registers, go to COMMIT.
  - counter == TIMEOUT-1 without done: unit_abort = 1, timeout_err = 1, HI/LO unchanged, go to IDLE.
- COMMIT: hi/lo <= pending, done = 1, stall = 0, go to IDLE. The held instruction leaves EX at this edge, so the same request is not re-accepted.
- Flush:
  - In ISSUE/WAIT: unit_abort = 1, go to IDLE, HI/LO unchanged. unit_start is suppressed if flush arrives in ISSUE.
  - In COMMIT: write and done are suppressed.
  - In IDLE: the request is ignored.
  - Flush has priority over unit_done in the same cycle.
- req_op/req_valid are ignored outside IDLE; the pipeline holds EX stable under stall.
- unit_done outside WAIT is ignored.
- Latency for a long op: issue edge, then engine latency N, then one commit cycle. HI/LO visible N+3 cycles after acceptance.
- hi/lo are registered outputs. No same-cycle forwarding of a commit; the consumer's hazard logic uses done.

Decomposition:
- muldiv_pkg: req_op enum, state enum, and the TIMEOUT default constant.
- One sub-module, muldiv_watchdog: counter with clear/enable and an expired output.
- The FSM and the HI/LO registers stay in muldiv_scheduler.

Test Plan:
- Reset mid-WAIT (rst low for 1 cycle): next cycle state IDLE, hi=lo=0, stall=0, no unit_start.
- MULT a=0xFFFFFFFE, b=3; engine returns after 5 cycles with hi=0xFFFFFFFF, lo=0xFFFFFFFA:
  - unit_signed=1, unit_is_div=0, one unit_start pulse, stall high 7 cycles.
  - done pulse, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIVU a=100, b=7: quotient 14 / remainder 2 → lo=14, hi=2. DIVU b=0: no unit_start, no stall, hi/lo unchanged, done next cycle.
- MTHI 0x12345678 followed immediately by MTLO 0x9ABCDEF0: hi/lo updated on consecutive edges, stall never asserted.
- Flush during WAIT cycle 2, then a late unit_done: unit_abort pulses, HI/LO unchanged, the late done is ignored, next MULT accepted normally.
- TIMEOUT=8 with engine never done: unit_abort and timeout_err pulse once 8 cycles after WAIT entry, stall drops, HI/LO unchanged.
